// File: rtl/sig_gen_ctrl.sv
// Front-panel controller for the four-waveform DDS generator: key pulses edit a
// pending register set, commits copy it to the active selects behind a timed confirm-low restart.
module sig_gen_ctrl #(
    parameter int SWEEP_DIV   = 50_000_000,
    parameter int RESTART_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_sel,
    input  logic       key_up,
    input  logic       key_ok,
    input  logic       key_stop,
    input  logic       sweep_en,
    output logic [1:0] cnt_sig,
    output logic [1:0] cnt_amp,
    output logic [1:0] cnt_fre,
    output logic [1:0] cnt_phase,
    output logic       confirm,
    output logic [1:0] field,
    output logic [7:0] pend,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int TW = $clog2(SWEEP_DIV);
    localparam int RW = $clog2(RESTART_CYC + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(SWEEP_DIV - 1);
    localparam logic [RW-1:0] RCNT_LOAD = RW'(RESTART_CYC - 1);
    localparam logic [7:0] SEL_RESET = 8'h10;

    typedef enum logic [1:0] {
        ST_STOP    = 2'd0,
        ST_RESTART = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    act_q, act_d;
    logic [7:0]    pend_q, pend_d;
    logic [1:0]    field_q, field_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          confirm_q, busy_q;
    logic          tick;
    logic [1:0]    fre_step;

    // Select vectors are packed {sig, amp, fre, phase}, matching the display bus.
    assign tick     = (state_q == ST_RUN) && sweep_en && (tmr_q == TMR_LAST);
    assign fre_step = act_q[3:2] + 2'd1;

    always_comb begin
        pend_d  = pend_q;
        field_d = field_q;
        state_d = state_q;
        act_d   = act_q;
        rcnt_d  = rcnt_q;
        tmr_d   = '0;

        if (key_up) begin
            case (field_q)
                2'd0:    pend_d[7:6] = pend_q[7:6] + 2'd1;
                2'd1:    pend_d[5:4] = pend_q[5:4] + 2'd1;
                2'd2:    pend_d[3:2] = pend_q[3:2] + 2'd1;
                default: pend_d[1:0] = pend_q[1:0] + 2'd1;
            endcase
        end
        if (key_sel) begin
            field_d = field_q + 2'd1;
        end

        case (state_q)
            ST_STOP: begin
                if (key_ok) begin
                    act_d   = pend_q;
                    rcnt_d  = RCNT_LOAD;
                    state_d = ST_RESTART;
                end
            end
            ST_RESTART: begin
                if (key_stop) begin
                    state_d = ST_STOP;
                end else if (key_ok) begin
                    act_d  = pend_q;
                    rcnt_d = RCNT_LOAD;
                end else if (rcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    rcnt_d = rcnt_q - RW'(1);
                end
            end
            ST_RUN: begin
                if (key_stop) begin
                    state_d = ST_STOP;
                end else if (key_ok) begin
                    act_d   = pend_q;
                    rcnt_d  = RCNT_LOAD;
                    state_d = ST_RESTART;
                end else if (tick) begin
                    // The sweep value wins over a same-cycle key_up on the fre field.
                    act_d[3:2]  = fre_step;
                    pend_d[3:2] = fre_step;
                    rcnt_d      = RCNT_LOAD;
                    state_d     = ST_RESTART;
                end else if (sweep_en) begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_STOP;
            act_q     <= SEL_RESET;
            pend_q    <= SEL_RESET;
            field_q   <= 2'd0;
            tmr_q     <= '0;
            rcnt_q    <= '0;
            confirm_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            pend_q    <= pend_d;
            field_q   <= field_d;
            tmr_q     <= tmr_d;
            rcnt_q    <= rcnt_d;
            confirm_q <= (state_d == ST_RUN);
            busy_q    <= (state_d == ST_RESTART);
        end
    end

    assign cnt_sig   = act_q[7:6];
    assign cnt_amp   = act_q[5:4];
    assign cnt_fre   = act_q[3:2];
    assign cnt_phase = act_q[1:0];
    assign confirm   = confirm_q;
    assign busy      = busy_q;
    assign field     = field_q;
    assign pend      = pend_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sig_gen_ctrl.sv
// Bench for sig_gen_ctrl: vector table, hand-written restart/sweep corners and a
// randomized run checked cycle by cycle against a behavioural panel model.
module tb_sig_gen_ctrl;

  localparam int SWEEP_DIV   = 8;
  localparam int RESTART_CYC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_sel, key_up, key_ok, key_stop, sweep_en;
  logic [1:0] cnt_sig, cnt_amp, cnt_fre, cnt_phase;
  logic       confirm, busy;
  logic [1:0] field;
  logic [7:0] pend;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];

  sig_gen_ctrl #(.SWEEP_DIV(SWEEP_DIV), .RESTART_CYC(RESTART_CYC)) dut (
    .clk(clk), .rst(rst),
    .key_sel(key_sel), .key_up(key_up), .key_ok(key_ok), .key_stop(key_stop),
    .sweep_en(sweep_en),
    .cnt_sig(cnt_sig), .cnt_amp(cnt_amp), .cnt_fre(cnt_fre), .cnt_phase(cnt_phase),
    .confirm(confirm), .field(field), .pend(pend), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Panel described as: output on/off, cycles of confirm-low left, cycles spent running.
  int m_act[4];
  int m_pend[4];
  int m_field;
  bit m_on;
  int m_low;
  int m_age;

  function automatic logic [19:0] model_vec();
    return {2'(m_act[0]), 2'(m_act[1]), 2'(m_act[2]), 2'(m_act[3]),
            (m_on && m_low == 0), (m_on && m_low > 0), 2'(m_field),
            2'(m_pend[0]), 2'(m_pend[1]), 2'(m_pend[2]), 2'(m_pend[3])};
  endfunction

  task automatic model_reset();
    m_act  = '{0, 1, 0, 0};
    m_pend = '{0, 1, 0, 0};
    m_field = 0;
    m_on = 0;
    m_low = 0;
    m_age = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic s, input logic u, input logic o, input logic p,
                            input logic w);
    int  np[4];
    bit  in_run, in_rst, tck;
    np = m_pend;
    in_run = m_on && (m_low == 0);
    in_rst = m_on && (m_low > 0);
    tck = in_run && w && (m_age == SWEEP_DIV - 1);
    if (u) np[m_field] = (np[m_field] + 1) % 4;
    if (s) m_field = (m_field + 1) % 4;
    if (p && m_on) begin
      m_on = 0; m_low = 0; m_age = 0;
    end else if (o) begin
      m_act = m_pend; m_on = 1; m_low = RESTART_CYC; m_age = 0;
    end else if (tck) begin
      m_act[2] = (m_act[2] + 1) % 4;
      np[2] = m_act[2];
      m_low = RESTART_CYC; m_age = 0;
    end else if (in_rst) begin
      m_low = m_low - 1;
    end else if (in_run) begin
      m_age = w ? m_age + 1 : 0;
    end
    m_pend = np;
    exp_q.push_back(model_vec());
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_out(input string name);
    logic [19:0] got, exp;
    got = {cnt_sig, cnt_amp, cnt_fre, cnt_phase, confirm, busy, field, pend};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s got=%0h exp=<none queued>", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s got=%05h exp=%05h", name, got, exp);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply(input logic s, input logic u, input logic o, input logic p,
                       input logic w);
    key_sel = s; key_up = u; key_ok = o; key_stop = p; sweep_en = w;
    @(posedge clk);
    model_step(s, u, o, p, w);
    #1;
    key_sel = 1'b0; key_up = 1'b0; key_ok = 1'b0; key_stop = 1'b0;
    check_out("model");
  endtask

  task automatic run_until(input logic lvl, input logic w, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b0, w);
      if (confirm === lvl) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_confirm got=timeout exp=level_%0b", lvl);
    end
  endtask

  typedef struct {
    logic       s, u, o, p;
    logic [1:0] sig, fre, fld;
    logic [7:0] pnd;
    logic       conf, bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic s, input logic u, input logic o, input logic p,
                         input logic [1:0] sig, input logic [1:0] fre, input logic [1:0] fld,
                         input logic [7:0] pnd, input logic conf, input logic bsy);
    vec_t v;
    v.s = s; v.u = u; v.o = o; v.p = p;
    v.sig = sig; v.fre = fre; v.fld = fld; v.pnd = pnd; v.conf = conf; v.bsy = bsy;
    tbl.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    int n;
    logic sw;

    //      sel up ok stop  sig fre fld pend   conf busy
    add_vec(1, 0, 0, 0,     0,  0,  1, 8'h10, 0,   0);
    add_vec(1, 0, 0, 0,     0,  0,  2, 8'h10, 0,   0);
    add_vec(0, 1, 0, 0,     0,  0,  2, 8'h14, 0,   0);
    add_vec(0, 1, 0, 0,     0,  0,  2, 8'h18, 0,   0);
    add_vec(0, 1, 0, 0,     0,  0,  2, 8'h1C, 0,   0);
    add_vec(0, 0, 1, 0,     0,  3,  2, 8'h1C, 0,   1);
    add_vec(0, 0, 0, 0,     0,  3,  2, 8'h1C, 0,   1);
    add_vec(0, 0, 0, 0,     0,  3,  2, 8'h1C, 0,   1);
    add_vec(0, 0, 0, 0,     0,  3,  2, 8'h1C, 0,   1);
    add_vec(0, 0, 0, 0,     0,  3,  2, 8'h1C, 1,   0);
    add_vec(0, 0, 0, 0,     0,  3,  2, 8'h1C, 1,   0);
    add_vec(1, 0, 0, 0,     0,  3,  3, 8'h1C, 1,   0);
    add_vec(1, 0, 0, 0,     0,  3,  0, 8'h1C, 1,   0);
    add_vec(0, 1, 0, 0,     0,  3,  0, 8'h5C, 1,   0);
    add_vec(0, 0, 1, 0,     1,  3,  0, 8'h5C, 0,   1);
    add_vec(0, 0, 0, 0,     1,  3,  0, 8'h5C, 0,   1);
    add_vec(0, 0, 0, 0,     1,  3,  0, 8'h5C, 0,   1);
    add_vec(0, 0, 0, 0,     1,  3,  0, 8'h5C, 0,   1);
    add_vec(0, 0, 0, 0,     1,  3,  0, 8'h5C, 1,   0);
    add_vec(0, 0, 1, 1,     1,  3,  0, 8'h5C, 0,   0);
    add_vec(0, 0, 0, 1,     1,  3,  0, 8'h5C, 0,   0);
    add_vec(0, 0, 1, 0,     1,  3,  0, 8'h5C, 0,   1);
    add_vec(0, 0, 0, 1,     1,  3,  0, 8'h5C, 0,   0);
    add_vec(0, 0, 0, 0,     1,  3,  0, 8'h5C, 0,   0);
    add_vec(0, 0, 0, 0,     1,  3,  0, 8'h5C, 0,   0);
    add_vec(0, 0, 0, 0,     1,  3,  0, 8'h5C, 0,   0);
    add_vec(0, 0, 0, 0,     1,  3,  0, 8'h5C, 0,   0);

    // clock/reset
    rst = 1'b1;
    key_sel = 1'b0; key_up = 1'b0; key_ok = 1'b0; key_stop = 1'b0; sweep_en = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    exp_q.push_back(model_vec());
    check_out("reset");
    check_eq("reset_pend", pend, 8'h10);
    @(negedge clk);
    rst = 1'b0;

    // vector table: edit/start, running re-commit, stop priority, stop in restart
    foreach (tbl[i]) begin
      apply(tbl[i].s, tbl[i].u, tbl[i].o, tbl[i].p, 1'b0);
      check_eq($sformatf("vec%0d", i),
               {cnt_sig, cnt_fre, field, pend, confirm, busy},
               {tbl[i].sig, tbl[i].fre, tbl[i].fld, tbl[i].pnd, tbl[i].conf, tbl[i].bsy});
    end

    // auto sweep from fre=3: wraps to 0, then steps to 1
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_until(1'b1, 1'b1, n);
    check_eq("sweep_restart_len0", n, 4);
    run_until(1'b0, 1'b1, n);
    check_eq("sweep_run_len0", n, SWEEP_DIV);
    check_eq("sweep_wrap_fre", cnt_fre, 2'd0);
    check_eq("sweep_wrap_pend_fre", pend[3:2], 2'd0);
    run_until(1'b1, 1'b1, n);
    check_eq("sweep_restart_len1", n, RESTART_CYC);
    run_until(1'b0, 1'b1, n);
    check_eq("sweep_run_len1", n, SWEEP_DIV);
    check_eq("sweep_step_fre", cnt_fre, 2'd1);

    // key_ok on the tick cycle commits pending instead of stepping
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_until(1'b1, 1'b1, n);
    repeat (SWEEP_DIV - 1) apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("tick_ok_sig", cnt_sig, 2'd2);
    check_eq("tick_ok_fre", cnt_fre, 2'd1);
    check_eq("tick_ok_confirm", confirm, 1'b0);
    run_until(1'b1, 1'b1, n);
    check_eq("tick_ok_restart_len", n, RESTART_CYC);
    run_until(1'b0, 1'b1, n);
    check_eq("tick_ok_run_len", n, SWEEP_DIV);
    check_eq("tick_ok_next_fre", cnt_fre, 2'd2);

    // sweep write beats a coincident key_up on the fre field
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_until(1'b1, 1'b1, n);
    repeat (SWEEP_DIV - 1) apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("tick_up_fre", cnt_fre, 2'd3);
    check_eq("tick_up_pend_fre", pend[3:2], 2'd3);

    // randomized stimulus against the model
    sw = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) sw = ~sw;
      apply(($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 39) == 0), sw);
    end

    // asynchronous reset in the middle of RUN
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_until(1'b1, 1'b0, n);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(model_vec());
    check_out("async_reset");
    check_eq("async_reset_amp", cnt_amp, 2'd1);
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
